// File: rtl/svfloat_norm_round.sv
// svfloat_norm_round: multi-cycle normalize-and-round stage for int-to-float.
// A sign/magnitude pair is normalized one bit per cycle and then rounded
// to nearest-even into a packed float with sign/exponent/mantissa fields.

package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;
endpackage

// Elaboration-time parameter checks: every nonzero result must be normal.
module svfloat_norm_round_chk #(
  parameter int bias  = 127,
  parameter int width = 32,
  parameter int frac  = 0
) ();
  if (width < 2) begin : g_bad_width
    $error("svfloat_norm_round: width must be at least 2");
  end
  if (!((width - 1 - frac) < bias) || !(frac < bias)) begin : g_bad_range
    $error("svfloat_norm_round: magnitude range exceeds float exponent range");
  end
endmodule

module svfloat_norm_round #(
  parameter type float = svfloat::float32,
  parameter int  width = 32,
  parameter int  frac  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [width-1:0] in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output float             out,
  output logic             out_inexact
);

  localparam int E    = $bits(out.exponent);
  localparam int M    = $bits(out.mantissa);
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int W1   = width - 1;
  localparam int CW   = $clog2(width) + 1;
  localparam int EW   = (CW + 1 > E + 1) ? (CW + 1) : (E + 1);
  localparam int XW   = W1 + M + 2;

  svfloat_norm_round_chk #(.bias(BIAS), .width(width), .frac(frac)) u_chk ();

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [width-1:0] mag_q, mag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  float             out_q, out_d;
  logic             inexact_q, inexact_d;

  // Rounding datapath; the magnitude below the hidden bit is padded with
  // M+2 zeros so guard/sticky naturally read 0 when the fraction fits.
  logic [XW-1:0]      ext_s;
  logic [M-1:0]       mant_s;
  logic               guard_s;
  logic               sticky_s;
  logic               inc_s;
  logic [M:0]         mant_sum_s;
  logic               carry_s;
  logic signed [EW-1:0] exp_s;
  logic               unused_exp_s;

  // Mantissa extraction, round-to-nearest-even and exponent from shift count.
  always_comb begin
    ext_s      = {mag_q[W1-1:0], {(M + 2){1'b0}}};
    mant_s     = ext_s[XW-1 -: M];
    guard_s    = ext_s[W1+1];
    sticky_s   = |ext_s[W1:0];
    inc_s      = guard_s & (sticky_s | mant_s[0]);
    mant_sum_s = {1'b0, mant_s} + {{M{1'b0}}, inc_s};
    carry_s    = mant_sum_s[M];
    exp_s      = $signed(EW'(BIAS + W1 - frac)) - $signed(EW'(cnt_q))
               + $signed(EW'(carry_s));
  end

  assign unused_exp_s = ^exp_s[EW-1:E];

  // Next-state and datapath register updates for the four-state sequencer.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    inexact_d = inexact_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign & (in_mag != {width{1'b0}});
          mag_d   = in_mag;
          cnt_d   = {CW{1'b0}};
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (mag_q[width-1] || (mag_q == {width{1'b0}})) begin
          state_d = ROUND;
        end else begin
          mag_d   = {mag_q[width-2:0], 1'b0};
          cnt_d   = cnt_q + {{(CW - 1){1'b0}}, 1'b1};
          state_d = SHIFT;
        end
      end
      ROUND: begin
        if (mag_q == {width{1'b0}}) begin
          out_d     = '0;
          inexact_d = 1'b0;
        end else begin
          out_d          = '0;
          out_d.sign     = sign_q;
          out_d.exponent = exp_s[E-1:0];
          out_d.mantissa = mant_sum_s[M-1:0];
          inexact_d      = guard_s | sticky_s;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset aborting any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= {width{1'b0}};
      cnt_q     <= {CW{1'b0}};
      out_q     <= '0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      inexact_q <= inexact_d;
    end
  end

  assign in_ready    = (state_q == IDLE) & ~rst;
  assign out_valid   = (state_q == DONE);
  assign out         = out_q;
  assign out_inexact = inexact_q;

endmodule
